// File: rtl/dbg_busmst.sv
// Debug bus initiator: turns upstream read/write commands into single dbg bus transfers.
// Latency: 3 cycles from command acceptance to rsp_valid when the responder answers at once.
// Backpressure: one command in flight; up_ready only in IDLE, result held until rsp_ready.
// Optional: DBG_BUSMST_TIMEOUT_EN adds a TMO-cycle bus response timeout (rsp_err=2).

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module dbg_busmst #(
  parameter int AW  = 6,    // bus address width, must be >= 2 for the alignment check
  parameter int TMO = 255   // bus response timeout in REQ cycles, >= 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic                      up_w_rb,
  input  logic [AW-1:0]             up_addr,
  input  logic                      up_addr_ld,
  input  logic                      up_autoinc,
  input  logic [`BUS_ACC_WIDTH-1:0] up_acc,
  input  logic [`BUS_WIDTH-1:0]     up_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [`BUS_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [AW-1:0]             bus_addr,
  output logic                      bus_w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] bus_acc,
  output logic [`BUS_WIDTH-1:0]     bus_wdata,
  output logic                      bus_req,
  input  logic [`BUS_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_resp,
  input  logic                      bus_fault
);

  if (TMO < 1) begin : g_bad_tmo
    $error("dbg_busmst: TMO must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, CHK, REQ, RSP} state_t;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_FAULT = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_ILL   = 2'd3;

  state_t                      state_q, state_d;
  logic                        cmd_w_rb, cmd_addr_ld, cmd_autoinc;
  logic [AW-1:0]               cmd_addr;
  logic [`BUS_ACC_WIDTH-1:0]   cmd_acc;
  logic [`BUS_WIDTH-1:0]       cmd_wdata;
  logic [AW-1:0]               addr_q;
  logic [`BUS_WIDTH-1:0]       rdata_q;
  logic [1:0]                  err_q;

  logic [AW-1:0]               eff_addr;
  logic [AW-1:0]               acc_step;
  logic                        illegal;
  logic                        tmo_hit;

  // Address the access will use, its legality and the autoincrement step.
  always_comb begin
    eff_addr = cmd_addr_ld ? cmd_addr : addr_q;
    illegal  = 1'b0;
    acc_step = '0;
    case (cmd_acc)
      2'd0:    acc_step = AW'(1);
      2'd1:    begin acc_step = AW'(2); illegal = eff_addr[0]; end
      2'd2:    begin acc_step = AW'(4); illegal = (eff_addr[1:0] != 2'b00); end
      default: illegal = 1'b1;
    endcase
  end

`ifdef DBG_BUSMST_TIMEOUT_EN
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [CW-1:0] tmo_cnt;

  // Count REQ cycles; cleared while in CHK so every bus transfer starts from zero.
  always_ff @(posedge clk) begin
    if (!rstn)                tmo_cnt <= '0;
    else if (state_q == CHK)  tmo_cnt <= '0;
    else if (state_q == REQ)  tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign tmo_hit = (state_q == REQ) && (tmo_cnt == CW'(TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a response in the same cycle as timeout expiry wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (up_valid) state_d = CHK;
      CHK:     state_d = illegal ? RSP : REQ;
      REQ:     if (bus_resp || tmo_hit) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, address register and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_w_rb    <= 1'b0;
      cmd_addr_ld <= 1'b0;
      cmd_autoinc <= 1'b0;
      cmd_addr    <= '0;
      cmd_acc     <= '0;
      cmd_wdata   <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: if (up_valid) begin
          cmd_w_rb    <= up_w_rb;
          cmd_addr_ld <= up_addr_ld;
          cmd_autoinc <= up_autoinc;
          cmd_addr    <= up_addr;
          cmd_acc     <= up_acc;
          cmd_wdata   <= up_wdata;
        end
        // An illegal access leaves the address register untouched, even with a load.
        CHK: if (illegal) begin
          err_q   <= ERR_ILL;
          rdata_q <= '0;
        end else begin
          addr_q  <= eff_addr;
        end
        REQ: if (bus_resp) begin
          rdata_q <= (cmd_w_rb || bus_fault) ? '0 : bus_rdata;
          err_q   <= bus_fault ? ERR_FAULT : ERR_OK;
          if (!bus_fault && cmd_autoinc) addr_q <= addr_q + acc_step;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= ERR_TMO;
        end
        default: ;
      endcase
    end
  end

  assign up_ready  = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign bus_req   = (state_q == REQ);
  assign bus_addr  = addr_q;
  assign bus_w_rb  = cmd_w_rb;
  assign bus_acc   = cmd_acc;
  assign bus_wdata = cmd_wdata;

endmodule
